// File: rtl/ahb_periph_decoder_mux_pkg.sv
// Shared constants and encodings for the AHB peripheral decoder/mux slice:
// slot count, default-slave states, HTRANS and HRESP values.
package ahb_periph_decoder_mux_pkg;

    localparam int unsigned NSLOT = 4;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: answers active transfers with a
// two-cycle ERROR response; IDLE/BUSY transfers get a zero-wait OKAY.
module ahb_default_slave
    import ahb_periph_decoder_mux_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        def_hit,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    output logic        ready,
    output logic        resp,
    output logic [31:0] rdata
);

    ds_state_e state;
    logic      active;
    logic      qualify;

    always_comb begin
        active  = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
        qualify = def_hit && HREADY && active;
    end

    assign rdata = '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
            ready <= 1'b1;
            resp  <= HRESP_OKAY;
        end else begin
            unique case (state)
                DS_IDLE: begin
                    if (qualify) begin
                        state <= DS_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state <= DS_ERR2;
                    ready <= 1'b1;
                    resp  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // A fresh unmapped transfer accepted on the closing cycle chains a new error
                    if (qualify) begin
                        state <= DS_ERR1;
                        ready <= 1'b0;
                        resp  <= HRESP_ERROR;
                    end else begin
                        state <= DS_IDLE;
                        ready <= 1'b1;
                        resp  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state <= DS_IDLE;
                    ready <= 1'b1;
                    resp  <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_periph_decoder_mux.sv
// AHB-Lite decoder and response mux for four peripheral slots (slot 0 = RCC)
// plus an internal default slave for unmapped addresses.
module ahb_periph_decoder_mux
    import ahb_periph_decoder_mux_pkg::*;
#(
    parameter logic [15:0] BASE0 = 16'h4002,
    parameter logic [15:0] BASE1 = 16'h4003,
    parameter logic [15:0] BASE2 = 16'h4004,
    parameter logic [15:0] BASE3 = 16'h4005
)
(
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic [1:0]          HTRANS,
    input  logic [31:0]         HADDR,
    output logic [NSLOT-1:0]    HSEL_S,
    input  logic [NSLOT-1:0]    HREADYOUT_S,
    input  logic [NSLOT-1:0]    HRESP_S,
    input  logic [32*NSLOT-1:0] HRDATA_S,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA
);

    localparam logic [15:0] BASES [NSLOT] = '{BASE0, BASE1, BASE2, BASE3};

    logic           found;
    logic           def_hit;
    logic [NSLOT:0] dsel;
    logic           ds_ready;
    logic           ds_resp;
    logic [31:0]    ds_rdata;
    logic           unused_addr;

    assign unused_addr = ^HADDR[15:0];

    // Lowest matching index wins so overlapping bases still give a one-hot select
    always_comb begin
        HSEL_S = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (HSEL && (HADDR[31:16] == BASES[i]) && !found) begin
                HSEL_S[i] = 1'b1;
                found     = 1'b1;
            end
        end
        def_hit = HSEL && !found;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= '0;
        end else if (HREADY) begin
            dsel <= {def_hit, HSEL_S};
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .def_hit (def_hit),
        .HREADY  (HREADY),
        .HTRANS  (HTRANS),
        .ready   (ds_ready),
        .resp    (ds_resp),
        .rdata   (ds_rdata)
    );

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        if (dsel[NSLOT]) begin
            HREADYOUT = ds_ready;
            HRESP     = ds_resp;
            HRDATA    = ds_rdata;
        end else begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (dsel[i]) begin
                    HREADYOUT = HREADYOUT_S[i];
                    HRESP     = HRESP_S[i];
                    HRDATA    = HRDATA_S[32*i +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_periph_decoder_mux.sv
// Directed self-checking bench for ahb_periph_decoder_mux; HREADY is looped
// back from HREADYOUT as in a single-slave region.
module tb_ahb_periph_decoder_mux;

    logic         HCLK;
    logic         HRESETn;
    logic         HSEL;
    logic         HREADY;
    logic [1:0]   HTRANS;
    logic [31:0]  HADDR;
    logic [3:0]   HSEL_S;
    logic [3:0]   HREADYOUT_S;
    logic [3:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic         HREADYOUT;
    logic         HRESP;
    logic [31:0]  HRDATA;

    int n_checks = 0;
    int n_fail   = 0;

    assign HREADY = HREADYOUT;

    ahb_periph_decoder_mux #(
        .BASE0 (16'h4002),
        .BASE1 (16'h4003),
        .BASE2 (16'h4004),
        .BASE3 (16'h4005)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HREADY      (HREADY),
        .HTRANS      (HTRANS),
        .HADDR       (HADDR),
        .HSEL_S      (HSEL_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance one cycle; inputs are then driven 1 time unit after the edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
        HREADYOUT_S = 4'hF; HRESP_S = 4'h0;
        HRDATA_S = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA5A5_0001};
        #12;
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b expected 0", HRESP); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA); end
        n_checks++; if (HSEL_S !== 4'b0000) begin n_fail++; $display("FAIL reset_hsel_s: got %b expected 0000", HSEL_S); end
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        HSEL = 1'b1; HTRANS = 2'b10;
        HADDR = 32'h4003_0010; #1;
        n_checks++; if (HSEL_S !== 4'b0010) begin n_fail++; $display("FAIL decode_slot1: got %b expected 0010", HSEL_S); end
        HADDR = 32'h4005_FFFC; #1;
        n_checks++; if (HSEL_S !== 4'b1000) begin n_fail++; $display("FAIL decode_slot3: got %b expected 1000", HSEL_S); end
        HADDR = 32'h4001_FFFC; #1;
        n_checks++; if (HSEL_S !== 4'b0000) begin n_fail++; $display("FAIL decode_below: got %b expected 0000", HSEL_S); end
        HSEL = 1'b0; HADDR = 32'h4004_0000; #1;
        n_checks++; if (HSEL_S !== 4'b0000) begin n_fail++; $display("FAIL decode_hsel_low: got %b expected 0000", HSEL_S); end
        HTRANS = 2'b00;
        tick();
    endtask

    task automatic test_read_slot0();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4002_0000; #1;
        n_checks++; if (HSEL_S !== 4'b0001) begin n_fail++; $display("FAIL rd0_hsel_s: got %b expected 0001", HSEL_S); end
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; #1;
        n_checks++; if (HRDATA !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rd0_hrdata: got %h expected a5a50001", HRDATA); end
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rd0_hreadyout: got %b expected 1", HREADYOUT); end
        tick();
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL rd0_after_idle: got %h expected 0", HRDATA); end
        // Slot 1 ERROR passthrough
        HRESP_S = 4'b0010;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4003_0000;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; #1;
        n_checks++; if (HRESP !== 1'b1) begin n_fail++; $display("FAIL rd1_hresp: got %b expected 1", HRESP); end
        n_checks++; if (HRDATA !== 32'h1111_1111) begin n_fail++; $display("FAIL rd1_hrdata: got %h expected 11111111", HRDATA); end
        HRESP_S = 4'b0000;
        tick();
    endtask

    task automatic test_unmapped_error();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4009_0000; #1;
        n_checks++; if (HSEL_S !== 4'b0000) begin n_fail++; $display("FAIL unm_hsel_s: got %b expected 0000", HSEL_S); end
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; #1;
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_fail++; $display("FAIL unm_err1: got rdy/resp %b expected 01", {HREADYOUT, HRESP}); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL unm_hrdata: got %h expected 0", HRDATA); end
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_fail++; $display("FAIL unm_err2: got rdy/resp %b expected 11", {HREADYOUT, HRESP}); end
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL unm_done: got rdy/resp %b expected 10", {HREADYOUT, HRESP}); end
    endtask

    task automatic test_unmapped_idle();
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h4009_0000;
        tick();
        HTRANS = 2'b01; #1;
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL unm_idle: got rdy/resp %b expected 10", {HREADYOUT, HRESP}); end
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; #1;
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL unm_busy: got rdy/resp %b expected 10", {HREADYOUT, HRESP}); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Unmapped NONSEQ held through ERR1 is accepted again in ERR2
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4009_0000;
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_fail++; $display("FAIL b2b_err1a: got rdy/resp %b expected 01", {HREADYOUT, HRESP}); end
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_fail++; $display("FAIL b2b_err2a: got rdy/resp %b expected 11", {HREADYOUT, HRESP}); end
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_fail++; $display("FAIL b2b_err1b: got rdy/resp %b expected 01", {HREADYOUT, HRESP}); end
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_fail++; $display("FAIL b2b_err2b: got rdy/resp %b expected 11", {HREADYOUT, HRESP}); end
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle: got rdy/resp %b expected 10", {HREADYOUT, HRESP}); end
    endtask

    task automatic test_slot_wait();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4004_0000; HREADYOUT_S = 4'b1011;
        tick();
        HADDR = 32'h4003_0000; #1;
        n_checks++; if (HSEL_S !== 4'b0010) begin n_fail++; $display("FAIL wait_hsel_s: got %b expected 0010", HSEL_S); end
        for (int c = 0; c < 3; c++) begin
            n_checks++; if ({HREADYOUT, HRDATA} !== {1'b0, 32'h2222_2222}) begin n_fail++; $display("FAIL wait_cycle%0d: got rdy %b data %h expected 0 22222222", c, HREADYOUT, HRDATA); end
            if (c < 2) tick();
        end
        tick();
        HREADYOUT_S = 4'b1111; #1;
        n_checks++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h2222_2222}) begin n_fail++; $display("FAIL wait_release: got rdy %b data %h expected 1 22222222", HREADYOUT, HRDATA); end
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; #1;
        n_checks++; if ({HREADYOUT, HRDATA} !== {1'b1, 32'h1111_1111}) begin n_fail++; $display("FAIL wait_switch: got rdy %b data %h expected 1 11111111", HREADYOUT, HRDATA); end
        tick();
    endtask

    task automatic test_reset_mid_error();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4009_0000;
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_fail++; $display("FAIL rst_pre_err1: got rdy/resp %b expected 01", {HREADYOUT, HRESP}); end
        #2; HRESETn = 1'b0; #1;
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL rst_async: got rdy/resp %b expected 10", {HREADYOUT, HRESP}); end
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        HRESETn = 1'b1;
        tick();
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL rst_release: got rdy/resp %b expected 10", {HREADYOUT, HRESP}); end
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4005_0004; #1;
        n_checks++; if (HSEL_S !== 4'b1000) begin n_fail++; $display("FAIL rst_slot3_sel: got %b expected 1000", HSEL_S); end
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; #1;
        n_checks++; if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h3333_3333}) begin n_fail++; $display("FAIL rst_slot3_data: got rdy %b resp %b data %h expected 1 0 33333333", HREADYOUT, HRESP, HRDATA); end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_read_slot0();
        test_unmapped_error();
        test_unmapped_idle();
        test_back_to_back();
        test_slot_wait();
        test_reset_mid_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_periph_decoder_mux.md
Name: ahb_periph_decoder_mux

Overview:
AHB-Lite slave-side decoder and response multiplexer placed directly upstream of the RCC and its sibling peripherals. It takes the region select from the system interconnect, decodes HADDR[31:16] into one-hot HSEL lines for four slave slots, and returns the selected slave's HREADYOUT/HRESP/HRDATA to the master. Slot 0 is the RCC. An internal default slave gives a two-cycle ERROR response to any active transfer that hits an unmapped address.

Parameters:
BASE0, 16'h4002, HADDR[31:16] match value for slot 0 (RCC)
BASE1, 16'h4003, HADDR[31:16] match value for slot 1
BASE2, 16'h4004, HADDR[31:16] match value for slot 2
BASE3, 16'h4005, HADDR[31:16] match value for slot 3

Ports:
HCLK  input  1  system bus clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  region select from the interconnect
HREADY  input  1  bus-wide ready
HTRANS  input  2  transfer type
HADDR  input  32  address
HSEL_S  output  4  one-hot slave selects; bit i drives slot i
HREADYOUT_S  input  4  per-slot ready
HRESP_S  input  4  per-slot response
HRDATA_S  input  128  per-slot read data; slot i occupies [32i+31:32i]
HREADYOUT  output  1  muxed ready to the master
HRESP  output  1  muxed response (0 = OKAY, 1 = ERROR)
HRDATA  output  32  muxed read data

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESETn is asynchronous and active-low. All flops clear on reset.
- Address-phase decode is combinational:
  - match[i] = HSEL && (HADDR[31:16] == BASEi).
  - If bases overlap, the lowest index wins, so HSEL_S is always one-hot or zero.
  - def_hit = HSEL && no match.
- HSEL_S = masked match vector. It is driven regardless of HTRANS and HREADY; the slaves qualify it with those signals.
- Data-phase select register dsel[4:0] holds {default, slot3..slot0}:
  - Loads on a rising HCLK when HREADY=1: {def_hit, HSEL_S}. If HSEL=0, it loads all zeros.
  - Holds while HREADY=0.
  - Reset value is 0.
- Response mux uses dsel:
  - dsel[i] set: outputs = slot i's HREADYOUT_S/HRESP_S/HRDATA_S.
  - dsel[4] set: outputs come from the default slave.
  - dsel zero: HREADYOUT=1, HRESP=0, HRDATA=32'h0.
- Reset value of outputs: HREADYOUT=1, HRESP=0, HRDATA=0, HSEL_S follows the combinational decode.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 when def_hit && HREADY && HTRANS[1]=1 (NONSEQ/SEQ).
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 if another qualifying def_hit is present in that cycle. Otherwise ERR2 -> IDLE.
- Default slave outputs:
  - IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - HRDATA is always 0.
- IDLE and BUSY transfers to an unmapped address get a zero-wait OKAY.
- Latency:
  - Mapped slot: data-phase latency equals the slave's own.
  - Unmapped address: exactly 2 data-phase cycles.
- Master abort on ERROR: if the master changes HTRANS to IDLE during ERR1, ERR2 still completes and the FSM then goes to IDLE.
- Reset mid-operation: FSM returns to IDLE and dsel clears immediately. No partial response is held after reset deasserts.
- Slot wait states: while a selected slot holds HREADYOUT_S=0, dsel holds. A new address phase presented during the wait is not captured until HREADY=1.

Decomposition:
- Shared package holds:
  - the slot count constant NSLOT=4;
  - the default-slave state encoding (IDLE=2'd0, ERR1=2'd1, ERR2=2'd2);
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ);
  - the HRESP OKAY/ERROR constants.
- One sub-module: ahb_default_slave, containing the FSM and its three outputs. Decode and mux stay in the top module.

Test Plan:
- Reset with HSEL=0 -> HREADYOUT=1, HRESP=0, HRDATA=0, HSEL_S=0.
- Read from 32'h4002_0000 with slot 0 HRDATA_S=32'hA5A5_0001 -> HSEL_S=4'b0001 in the address phase; HRDATA=32'hA5A5_0001 and HREADYOUT=1 in the next cycle.
- NONSEQ to 32'h4009_0000 -> data cycle 1 gives HREADYOUT=0, HRESP=1; cycle 2 gives HREADYOUT=1, HRESP=1; then IDLE/OKAY.
- IDLE transfer to 32'h4009_0000 -> HREADYOUT=1, HRESP=0 with no wait.
- Slot 2 stretches HREADYOUT_S[2]=0 for 3 cycles while the master presents slot 1's address -> outputs track slot 2 until it is ready; dsel switches to slot 1 only after HREADY=1.
- Assert HRESETn=0 during ERR1 -> HRESP=0 and HREADYOUT=1 immediately; after release, an OKAY access to slot 3 completes normally.
